// File: rtl/cpu_ctx_pkg.sv
// Context-switch encodings and defaults. The CPU uses the same constants to decode troca_contexto.
package cpu_ctx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SWITCH,
    ST_IOSW,
    ST_KERNEL
  } ctx_state_e;

  localparam logic [1:0] CTX_SWITCH = 2'b11;
  localparam logic [1:0] CTX_NONE   = 2'b00;
  localparam int         QDEF_DFLT  = 100;

endpackage

// File: rtl/context_switch_ctrl_quantum_counter.sv
// Loadable, saturating down-counter that tracks the remaining quantum of the running process.
module quantum_counter #(
  parameter int          QW      = 16,
  parameter logic [QW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [QW-1:0] load_val,
  input  logic          dec,
  output logic [QW-1:0] count,
  output logic          is_zero,
  output logic          is_one
);

  logic [QW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load)
      count_d = load_val;
    else if (dec && count_q != '0)
      count_d = count_q - QW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= RST_VAL;
    else       count_q <= count_d;
  end

  assign count   = count_q;
  assign is_zero = (count_q == '0);
  assign is_one  = (count_q == QW'(1));

endmodule

// File: rtl/context_switch_ctrl.sv
// Quantum-based preemption and IO-switch request generator that sits beside the CPU.
module context_switch_ctrl
  import cpu_ctx_pkg::*;
#(
  parameter int QW   = 16,
  parameter int QDEF = QDEF_DFLT,
  parameter int SCW  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           instr_retired,
  input  logic           io_instr,
  input  logic           ctx_return,
  input  logic           quantum_load,
  input  logic [QW-1:0]  quantum_in,
  output logic [1:0]     troca_contexto,
  output logic           io_contexto,
  output logic           in_kernel,
  output logic [QW-1:0]  quantum_left,
  output logic [SCW-1:0] switch_count
);

  ctx_state_e     state_q, state_d;
  logic [QW-1:0]  quantum_reg_q, quantum_reg_d;
  logic [1:0]     troca_q, troca_d;
  logic           io_q, io_d;
  logic           in_kernel_q, in_kernel_d;
  logic [SCW-1:0] switch_count_q, switch_count_d;

  logic          q_ld, q_dec, q_zero, q_one;
  logic [QW-1:0] q_ld_val;

  quantum_counter #(.QW(QW), .RST_VAL(QW'(QDEF))) u_qcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (q_ld),
    .load_val (q_ld_val),
    .dec      (q_dec),
    .count    (quantum_left),
    .is_zero  (q_zero),
    .is_one   (q_one)
  );

  always_comb begin
    state_d       = state_q;
    q_ld          = 1'b0;
    q_dec         = 1'b0;
    // A load arriving together with a resume takes effect immediately.
    q_ld_val      = quantum_load ? quantum_in : quantum_reg_q;
    quantum_reg_d = quantum_load ? quantum_in : quantum_reg_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_RUN;
          q_ld    = 1'b1;
        end
      end
      ST_RUN: begin
        q_dec = instr_retired && !q_zero;
        q_ld  = quantum_load;
        // IO beats disable beats expiry; a quantum load cancels a same-cycle expiry.
        if (io_instr)
          state_d = ST_IOSW;
        else if (!enable)
          state_d = ST_IDLE;
        else if (!quantum_load && quantum_reg_q != '0 && q_one && instr_retired)
          state_d = ST_SWITCH;
      end
      ST_SWITCH, ST_IOSW: state_d = ST_KERNEL;
      ST_KERNEL: begin
        if (ctx_return) begin
          state_d = ST_RUN;
          q_ld    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    troca_d        = (state_d == ST_SWITCH) ? CTX_SWITCH : CTX_NONE;
    io_d           = (state_d == ST_IOSW);
    in_kernel_d    = (state_d == ST_KERNEL);
    switch_count_d = switch_count_q + SCW'((state_d == ST_SWITCH) || io_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      quantum_reg_q  <= QW'(QDEF);
      troca_q        <= CTX_NONE;
      io_q           <= 1'b0;
      in_kernel_q    <= 1'b0;
      switch_count_q <= '0;
    end else begin
      state_q        <= state_d;
      quantum_reg_q  <= quantum_reg_d;
      troca_q        <= troca_d;
      io_q           <= io_d;
      in_kernel_q    <= in_kernel_d;
      switch_count_q <= switch_count_d;
    end
  end

  assign troca_contexto = troca_q;
  assign io_contexto    = io_q;
  assign in_kernel      = in_kernel_q;
  assign switch_count   = switch_count_q;

endmodule

// File: tb/tb_context_switch_ctrl.sv
// Directed bench for context_switch_ctrl: expiry, kernel blocking, IO priority, reloads, reset, wrap.
module tb_context_switch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, instr_retired, io_instr, ctx_return, quantum_load;
  logic [15:0] quantum_in;
  logic [1:0]  troca_contexto;
  logic        io_contexto, in_kernel;
  logic [15:0] quantum_left;
  logic [7:0]  switch_count;

  int n_cmp = 0;
  int n_err = 0;

  context_switch_ctrl #(.QW(16), .QDEF(100), .SCW(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .instr_retired  (instr_retired),
    .io_instr       (io_instr),
    .ctx_return     (ctx_return),
    .quantum_load   (quantum_load),
    .quantum_in     (quantum_in),
    .troca_contexto (troca_contexto),
    .io_contexto    (io_contexto),
    .in_kernel      (in_kernel),
    .quantum_left   (quantum_left),
    .switch_count   (switch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int bad;
    reset = 1'b1; enable = 1'b0; instr_retired = 1'b0; io_instr = 1'b0;
    ctx_return = 1'b0; quantum_load = 1'b0; quantum_in = '0;
    tick(); tick();
    chk("rst_troca", 32'(troca_contexto), 32'h0);
    chk("rst_io", 32'(io_contexto), 32'h0);
    chk("rst_kernel", 32'(in_kernel), 32'h0);
    chk("rst_qleft", 32'(quantum_left), 32'd100);
    chk("rst_count", 32'(switch_count), 32'h0);
    reset = 1'b0;

    // 1: quantum 5, expiry one cycle after 5th retirement
    quantum_load = 1'b1; quantum_in = 16'd5; tick();
    quantum_load = 1'b0; enable = 1'b1; tick();
    chk("t1_run_qleft", 32'(quantum_left), 32'd5);
    instr_retired = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (troca_contexto !== 2'b00) bad++;
    end
    chk("t1_no_early_troca", 32'(bad), 32'd0);
    chk("t1_qleft_1", 32'(quantum_left), 32'd1);
    tick();
    chk("t1_troca", 32'(troca_contexto), 32'h3);
    chk("t1_count", 32'(switch_count), 32'd1);
    chk("t1_qleft_0", 32'(quantum_left), 32'd0);
    tick();
    chk("t1_troca_pulse", 32'(troca_contexto), 32'h0);
    chk("t1_kernel", 32'(in_kernel), 32'h1);
    chk("t1_qleft_held", 32'(quantum_left), 32'd0);

    // 2: kernel ignores retirements and io_instr; ctx_return resumes with full quantum
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      io_instr = (i == 10);
      tick();
      if (troca_contexto !== 2'b00 || io_contexto !== 1'b0 || in_kernel !== 1'b1) bad++;
    end
    io_instr = 1'b0;
    chk("t2_kernel_quiet", 32'(bad), 32'd0);
    chk("t2_count_frozen", 32'(switch_count), 32'd1);
    chk("t2_qleft_frozen", 32'(quantum_left), 32'd0);
    instr_retired = 1'b0; ctx_return = 1'b1; tick();
    ctx_return = 1'b0;
    chk("t2_resume_qleft", 32'(quantum_left), 32'd5);
    chk("t2_resume_kernel", 32'(in_kernel), 32'h0);

    // 3: io_instr and final retirement together -> IO switch only
    instr_retired = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t3_qleft_1", 32'(quantum_left), 32'd1);
    io_instr = 1'b1; tick();
    io_instr = 1'b0; instr_retired = 1'b0;
    chk("t3_io", 32'(io_contexto), 32'h1);
    chk("t3_troca", 32'(troca_contexto), 32'h0);
    chk("t3_count", 32'(switch_count), 32'd2);
    tick();
    chk("t3_io_pulse", 32'(io_contexto), 32'h0);
    chk("t3_kernel", 32'(in_kernel), 32'h1);

    // 4: quantum 0 disables expiry; IO still switches
    quantum_load = 1'b1; quantum_in = 16'd0; tick();
    quantum_load = 1'b0; ctx_return = 1'b1; tick();
    ctx_return = 1'b0;
    chk("t4_qleft_0", 32'(quantum_left), 32'd0);
    instr_retired = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (troca_contexto !== 2'b00) bad++;
    end
    chk("t4_no_troca", 32'(bad), 32'd0);
    io_instr = 1'b1; tick();
    io_instr = 1'b0; instr_retired = 1'b0;
    chk("t4_io", 32'(io_contexto), 32'h1);
    chk("t4_count", 32'(switch_count), 32'd3);
    tick();
    chk("t4_kernel", 32'(in_kernel), 32'h1);

    // 5: load with same-cycle retirement overrides decrement
    quantum_load = 1'b1; quantum_in = 16'd5; ctx_return = 1'b1; tick();
    quantum_load = 1'b0; ctx_return = 1'b0;
    chk("t5_resume_qleft", 32'(quantum_left), 32'd5);
    instr_retired = 1'b1; tick(); tick();
    chk("t5_qleft_3", 32'(quantum_left), 32'd3);
    quantum_load = 1'b1; quantum_in = 16'd10; tick();
    quantum_load = 1'b0; instr_retired = 1'b0;
    chk("t5_qleft_10", 32'(quantum_left), 32'd10);
    chk("t5_no_troca", 32'(troca_contexto), 32'h0);

    // 6: reset during SWITCH, then switch_count wrap
    quantum_load = 1'b1; quantum_in = 16'd1; tick();
    quantum_load = 1'b0; instr_retired = 1'b1; tick();
    instr_retired = 1'b0;
    chk("t6_troca", 32'(troca_contexto), 32'h3);
    chk("t6_count", 32'(switch_count), 32'd4);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_troca", 32'(troca_contexto), 32'h0);
    chk("t6_rst_count", 32'(switch_count), 32'h0);
    chk("t6_rst_qleft", 32'(quantum_left), 32'd100);
    chk("t6_rst_kernel", 32'(in_kernel), 32'h0);
    enable = 1'b0;
    tick();
    reset = 1'b0; instr_retired = 1'b1;
    tick(); tick();
    chk("t6_idle_qleft", 32'(quantum_left), 32'd100);
    instr_retired = 1'b0; enable = 1'b1; tick();
    chk("t6_run_qdef", 32'(quantum_left), 32'd100);
    quantum_load = 1'b1; quantum_in = 16'd1; tick();
    quantum_load = 1'b0;
    bad = 0;
    for (int i = 1; i <= 256; i++) begin
      instr_retired = 1'b1; tick();
      if (troca_contexto !== 2'b11 || io_contexto !== 1'b0) bad++;
      instr_retired = 1'b0; tick();
      ctx_return = 1'b1; tick();
      ctx_return = 1'b0;
      if (i == 255) chk("t6_count_255", 32'(switch_count), 32'd255);
    end
    chk("t6_wrap_pulses", 32'(bad), 32'd0);
    chk("t6_count_wrap", 32'(switch_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
